// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: feeds an external combinational full adder one bit pair
// per clock (LSB first) and assembles the WIDTH-bit sum plus final carry.
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [WIDTH-1:0]   r_a_sr;
   logic [WIDTH-1:0]   r_b_sr;
   logic [WIDTH-1:0]   r_sum_sr;
   logic [WIDTH-1:0]   r_sum_out;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_carry;
   logic               r_cout_out;
   logic               w_last;
   logic               w_load;
   logic [WIDTH-1:0]   w_sum_next;

   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_load     = start && (r_state == StIdle || r_state == StDone);
   assign w_sum_next = {fa_sum, r_sum_sr[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      fa_a         = 1'b0;
      fa_b         = 1'b0;
      fa_cin       = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         StIdle: begin
            if (start) w_state_next = StRun;
         end
         StRun: begin
            busy   = 1'b1;
            fa_a   = r_a_sr[0];
            fa_b   = r_b_sr[0];
            fa_cin = r_carry;
            if (w_last) w_state_next = StDone;
         end
         StDone: begin
            done         = 1'b1;
            // A start in the done cycle chains straight into the next operation.
            w_state_next = start ? StRun : StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a_sr     <= '0;
         r_b_sr     <= '0;
         r_sum_sr   <= '0;
         r_sum_out  <= '0;
         r_cnt      <= '0;
         r_carry    <= 1'b0;
         r_cout_out <= 1'b0;
      end else if (w_load) begin
         r_a_sr   <= a_in;
         r_b_sr   <= b_in;
         r_carry  <= cin_in;
         r_cnt    <= '0;
         r_sum_sr <= '0;
      end else if (r_state == StRun) begin
         r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
         r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
         r_sum_sr <= w_sum_next;
         r_carry  <= fa_cout;
         r_cnt    <= r_cnt + 1'b1;
         if (w_last) begin
            r_sum_out  <= w_sum_next;
            r_cout_out <= fa_cout;
         end
      end
   end

   assign sum_out  = r_sum_out;
   assign cout_out = r_cout_out;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with a behavioural full adder closing the loop.
module tb_serial_adder_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic       cin_in;
   logic       fa_a;
   logic       fa_b;
   logic       fa_cin;
   logic       fa_sum;
   logic       fa_cout;
   logic       busy;
   logic       done;
   logic [7:0] sum_out;
   logic       cout_out;

   int checks = 0;
   int errors = 0;

   serial_adder_ctrl #(
      .WIDTH(8),
      .CNT_W(3)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a_in    (a_in),
      .b_in    (b_in),
      .cin_in  (cin_in),
      .fa_a    (fa_a),
      .fa_b    (fa_b),
      .fa_cin  (fa_cin),
      .fa_sum  (fa_sum),
      .fa_cout (fa_cout),
      .busy    (busy),
      .done    (done),
      .sum_out (sum_out),
      .cout_out(cout_out)
   );

   assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts an operation and walks it to its done cycle; returns sitting in that cycle.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic hold_start, input logic [7:0] cin_trace,
                         input logic [7:0] exp_sum, input logic exp_cout,
                         input logic [7:0] prev_sum, input logic prev_cout);
      a_in   = a;
      b_in   = b;
      cin_in = cin;
      start  = 1'b1;
      step();
      if (!hold_start) start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("busy_c%0d", i + 1), busy, 1'b1);
         check($sformatf("done_c%0d", i + 1), done, 1'b0);
         check($sformatf("fa_a_c%0d", i + 1), fa_a, a[i]);
         check($sformatf("fa_b_c%0d", i + 1), fa_b, b[i]);
         check($sformatf("fa_cin_c%0d", i + 1), fa_cin, cin_trace[i]);
         check($sformatf("sum_held_c%0d", i + 1), sum_out, prev_sum);
         check($sformatf("cout_held_c%0d", i + 1), cout_out, prev_cout);
         if (hold_start && i == 2) a_in = 8'hAA;
         step();
      end
      check("done_pulse", done, 1'b1);
      check("busy_in_done", busy, 1'b0);
      check("sum_out", sum_out, exp_sum);
      check("cout_out", cout_out, exp_cout);
      check("fa_idle", {fa_a, fa_b, fa_cin}, 3'b000);
   endtask

   task automatic check_idle(input string tag, input logic [7:0] exp_sum, input logic exp_cout);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_fa"}, {fa_a, fa_b, fa_cin}, 3'b000);
      check({tag, "_sum"}, sum_out, exp_sum);
      check({tag, "_cout"}, cout_out, exp_cout);
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      a_in   = 8'h00;
      b_in   = 8'h00;
      cin_in = 1'b0;
      step();
      step();
      check_idle("reset", 8'h00, 1'b0);
      reset = 1'b0;
      step();
      check_idle("post_reset", 8'h00, 1'b0);

      // 05 + 03: fa_cin ripples 0,1,1,1,0,0,0,0
      run_op(8'h05, 8'h03, 1'b0, 1'b0, 8'h0E, 8'h08, 1'b0, 8'h00, 1'b0);
      step();
      check_idle("after_op1", 8'h08, 1'b0);

      run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'hFE, 8'h00, 1'b1, 8'h08, 1'b0);
      step();
      check_idle("after_op2", 8'h00, 1'b1);

      run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1);
      step();
      check_idle("after_op3", 8'hFF, 1'b1);

      // start held through RUN, a_in changed mid-op; then chained load in the done cycle
      run_op(8'h05, 8'h03, 1'b0, 1'b1, 8'h0E, 8'h08, 1'b0, 8'hFF, 1'b1);
      run_op(8'h10, 8'h20, 1'b1, 1'b0, 8'h01, 8'h31, 1'b0, 8'h08, 1'b0);
      step();
      check_idle("after_b2b", 8'h31, 1'b0);

      // Reset in RUN cycle 4
      a_in   = 8'h55;
      b_in   = 8'h0F;
      cin_in = 1'b0;
      start  = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      check("busy_before_abort", busy, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_idle("abort", 8'h00, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("no_done_%0d", i), done, 1'b0);
      end

      run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'hFE, 8'h80, 1'b0, 8'h00, 1'b0);
      step();
      check_idle("final", 8'h80, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
